gpu_regfile: RTL and testbench
==============================

GPU_REGFILE -- requirements
Module: gpu_regfile

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter ADDR_W, default 4, register index width; depth = 2^ADDR_W.
REQ-003 Parameter DR_IDX, default 14, index of the data register mirrored on dr.
REQ-004 Parameter AR_IDX, default 15, index of the address register mirrored on ar and auto-incremented.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 rna, rnb, rnc  in  ADDR_W each  read indices for ports A, B and C.
REQ-008 qa, qb, qc  out  DATA_W each  combinational read data for ports A, B and C.
REQ-009 wn0, d0, we0  in  ADDR_W / DATA_W / 1  write port 0: index, data, enable.
REQ-010 wn1, d1, we1  in  ADDR_W / DATA_W / 1  write port 1: index, data, enable.
REQ-011 ar_inc  in  1  increment AR by 1 at the next edge.
REQ-012 dr  out  DATA_W  current stored contents of register DR_IDX.
REQ-013 ar  out  DATA_W  current stored contents of register AR_IDX.

Function
REQ-014 The block SHALL hold 2^ADDR_W registers of DATA_W bits; all are written only on the rising clock edge.
REQ-015 qa, qb and qc SHALL combinationally reflect the stored register selected by rna, rnb and rnc, subject to REQ-022.
REQ-016 we0=1 SHALL store d0 into register wn0 at the edge; we1=1 SHALL store d1 into register wn1 at the same edge.
REQ-017 If we0=we1=1 and wn0==wn1, port 1 SHALL win and d0 SHALL be discarded.
REQ-018 ar_inc=1 SHALL set AR to AR+1 modulo 2^DATA_W at the edge; 0xFFFF (DATA_W=16) SHALL wrap to 0x0000.
REQ-019 If ar_inc=1 in the same cycle as an enabled write to AR_IDX on either port, the write SHALL win and the increment SHALL be dropped.
REQ-020 dr and ar SHALL show stored contents only (no bypass) and SHALL update one edge after the write or increment.
REQ-021 Writes to other indices SHALL NOT disturb registers DR_IDX or AR_IDX.

Reset
REQ-022 resetn=0 SHALL clear every register asynchronously to 0, so qa, qb, qc, dr and ar read 0 while resetn is low.
REQ-023 Writes and ar_inc asserted while resetn=0 SHALL be ignored; the first edge after deassertion SHALL process inputs normally.
REQ-024 Reset asserted mid-operation SHALL discard any write or increment in the same cycle.

Configuration
REQ-025 Macro GPU_REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-026 Defined: a read port whose index matches an enabled write index in the same cycle SHALL return that write data combinationally; on a dual match, d1 SHALL win, consistent with REQ-017; ar_inc is not forwarded.
REQ-027 Undefined: read ports SHALL return stored contents only, and new data SHALL appear the cycle after the write.
REQ-028 dr, ar, reset behaviour and write semantics SHALL be identical in both builds.

Verification
REQ-029 Reset, then write d0=0x1001+i to index i for i=0..15 on consecutive cycles; then sweep rna 0..15 -> qa=0x1001+i, dr=0x100F, ar=0x1010.
REQ-030 In one cycle set we0=we1=1, wn0=wn1=3, d0=0xAAAA, d1=0x5555 -> register 3 reads 0x5555 next cycle.
REQ-031 Load AR=0xFFFE, then pulse ar_inc for 2 cycles -> ar=0xFFFF, then 0x0000; ar_inc together with we0 to AR_IDX with d0=0x0040 -> ar=0x0040.
REQ-032 Write 0x1234 to index 2 with rnb=2 in the same cycle -> qb=0x1234 in that cycle with GPU_REGFILE_BYPASS_EN, and the old value (0x0000 after reset) without it; both builds show 0x1234 next cycle.
REQ-033 Assert resetn=0 between edges after loading nonzero data -> all outputs read 0 immediately; a we0 held during reset leaves register contents 0.
REQ-034 Rebuild with DATA_W=32, ADDR_W=5, DR_IDX=30, AR_IDX=31, then repeat REQ-029 and REQ-031 -> identical behaviour, with AR wrap at 0xFFFFFFFF.

Source files
------------

// File: rtl/gpu_regfile.sv
// Register file with three combinational read ports, two write ports and a data/address register mirror.
// Optional write-to-read forwarding is enabled by defining GPU_REGFILE_BYPASS_EN.
module gpu_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DR_IDX = 14,
  parameter int AR_IDX = 15
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] rna,
  input  logic [ADDR_W-1:0] rnb,
  input  logic [ADDR_W-1:0] rnc,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] qc,
  input  logic [ADDR_W-1:0] wn0,
  input  logic [DATA_W-1:0] d0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wn1,
  input  logic [DATA_W-1:0] d1,
  input  logic              we1,
  input  logic              ar_inc,
  output logic [DATA_W-1:0] dr,
  output logic [DATA_W-1:0] ar
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] DR_A = ADDR_W'(DR_IDX);
  localparam logic [ADDR_W-1:0] AR_A = ADDR_W'(AR_IDX);

  logic [DATA_W-1:0] r_regs [DEPTH];

  // Later assignments override earlier ones: writes beat the increment, port 1 beats port 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (ar_inc) r_regs[AR_A] <= r_regs[AR_A] + DATA_W'(1);
      if (we0)    r_regs[wn0]  <= d0;
      if (we1)    r_regs[wn1]  <= d1;
    end
  end

`ifdef GPU_REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so all reads stay at zero.
  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] q);
    fwd = q;
    if (resetn) begin
      if (we0 && (wn0 == a)) fwd = d0;
      if (we1 && (wn1 == a)) fwd = d1;
    end
  endfunction

  always_comb begin
    qa = fwd(rna, r_regs[rna]);
    qb = fwd(rnb, r_regs[rnb]);
    qc = fwd(rnc, r_regs[rnc]);
  end
`else
  always_comb begin
    qa = r_regs[rna];
    qb = r_regs[rnb];
    qc = r_regs[rnc];
  end
`endif

  assign dr = r_regs[DR_A];
  assign ar = r_regs[AR_A];

endmodule

// File: tb/tb_gpu_regfile.sv
// Scoreboard bench for gpu_regfile (default parameters); expectations follow the
// GPU_REGFILE_BYPASS_EN setting of the build.
module tb_gpu_regfile;
  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  rna, rnb, rnc, wn0, wn1;
  logic [15:0] qa, qb, qc, d0, d1, dr, ar;
  logic        we0, we1, ar_inc;

  typedef struct {
    string       name;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];
  int compared   = 0;
  int mismatched = 0;

`ifdef GPU_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  gpu_regfile dut (
    .clock(clock), .resetn(resetn),
    .rna(rna), .rnb(rnb), .rnc(rnc),
    .qa(qa), .qb(qb), .qc(qc),
    .wn0(wn0), .d0(d0), .we0(we0),
    .wn1(wn1), .d1(d1), .we1(we1),
    .ar_inc(ar_inc), .dr(dr), .ar(ar)
  );

  always #5 clock = ~clock;

  task automatic push(input string name, input int sel, input logic [15:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops every expectation queued for this cycle and samples on the falling edge.
  always @(negedge clock) begin
    while (sbq.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sbq.pop_front();
      case (e.sel)
        0: act = qa;
        1: act = qb;
        2: act = qc;
        3: act = dr;
        default: act = ar;
      endcase
      compared++;
      if (act !== e.exp) begin
        mismatched++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    rna = 4'd0; rnb = 4'd5; rnc = 4'd15;
    wn0 = '0; wn1 = '0; d0 = '0; d1 = '0;
    we0 = 1'b0; we1 = 1'b0; ar_inc = 1'b0;
    step();
    push("rst_qa", 0, 16'h0000); push("rst_qb", 1, 16'h0000);
    push("rst_qc", 2, 16'h0000); push("rst_dr", 3, 16'h0000);
    push("rst_ar", 4, 16'h0000);
    step();
    resetn = 1'b1;
    step();

    // Same-cycle read of a register being written
    we0 = 1'b1; wn0 = 4'd2; d0 = 16'h1234; rnb = 4'd2;
    push("byp_qb_same", 1, BYP ? 16'h1234 : 16'h0000);
    step();
    we0 = 1'b0;
    push("byp_qb_next", 1, 16'h1234);
    step();

    // Fill all sixteen registers, then sweep port A
    for (int i = 0; i < 16; i++) begin
      we0 = 1'b1; wn0 = 4'(i); d0 = 16'h1001 + 16'(i);
      step();
    end
    we0 = 1'b0;
    push("fill_dr", 3, 16'h100F);
    push("fill_ar", 4, 16'h1010);
    for (int i = 0; i < 16; i++) begin
      rna = 4'(i);
      push($sformatf("sweep_qa%0d", i), 0, 16'h1001 + 16'(i));
      step();
    end

    // Dual write to one index: port 1 wins
    we0 = 1'b1; we1 = 1'b1; wn0 = 4'd3; wn1 = 4'd3; d0 = 16'hAAAA; d1 = 16'h5555;
    rnc = 4'd3;
    push("dual_qc_same", 2, BYP ? 16'h5555 : 16'h1004);
    step();
    we0 = 1'b0; we1 = 1'b0;
    rna = 4'd3; rnb = 4'd2;
    push("dual_qa", 0, 16'h5555);
    push("dual_qb_other", 1, 16'h1003);
    push("dual_dr", 3, 16'h100F);
    step();

    // AR load, increment and wrap
    we0 = 1'b1; wn0 = 4'd15; d0 = 16'hFFFE;
    step();
    we0 = 1'b0;
    push("ar_load", 4, 16'hFFFE);
    ar_inc = 1'b1;
    step();
    push("ar_inc1", 4, 16'hFFFF);
    step();
    ar_inc = 1'b0;
    push("ar_wrap", 4, 16'h0000);
    step();
    ar_inc = 1'b1; we0 = 1'b1; wn0 = 4'd15; d0 = 16'h0040;
    step();
    we0 = 1'b0; ar_inc = 1'b0;
    push("ar_w0_wins", 4, 16'h0040);
    ar_inc = 1'b1; we1 = 1'b1; wn1 = 4'd15; d1 = 16'h0100;
    step();
    we1 = 1'b0;
    push("ar_w1_wins", 4, 16'h0100);
    // Increment alongside a DR write; outputs lag by one edge
    we0 = 1'b1; wn0 = 4'd14; d0 = 16'hBEEF;
    push("dr_no_bypass", 3, 16'h100F);
    push("ar_before_inc", 4, 16'h0100);
    step();
    we0 = 1'b0; ar_inc = 1'b0;
    push("dr_written", 3, 16'hBEEF);
    push("ar_inc_other", 4, 16'h0101);
    step();

    // Mid-cycle reset with a write and increment pending
    resetn = 1'b0;
    we0 = 1'b1; wn0 = 4'd5; d0 = 16'h7777; ar_inc = 1'b1;
    rna = 4'd5; rnb = 4'd3; rnc = 4'd2;
    push("mrst_qa", 0, 16'h0000); push("mrst_qb", 1, 16'h0000);
    push("mrst_qc", 2, 16'h0000); push("mrst_dr", 3, 16'h0000);
    push("mrst_ar", 4, 16'h0000);
    step();
    push("mrst_hold_qa", 0, 16'h0000);
    step();
    we0 = 1'b0; ar_inc = 1'b0;
    resetn = 1'b1;
    push("post_rst_qa", 0, 16'h0000);
    push("post_rst_ar", 4, 16'h0000);
    step();
    we0 = 1'b1; wn0 = 4'd6; d0 = 16'h0606;
    step();
    we0 = 1'b0; rna = 4'd6;
    push("first_write", 0, 16'h0606);
    step();
    step();

    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
